cp0_regfile: RTL and testbench

- Coprocessor-0 register file for the MIPS pipeline. It holds SR (12), Cause (13), EPC (14) and PrID (15).
- It decides when an interrupt or exception is taken and produces the request consumed by the interrupt/exception control stage.
- It applies that stage's EXL/BD set/clear strobes and supplies EPC back for eret.
- It sits alongside the M stage; mtc0/mfc0 access it there.

---
 rtl/cp0_regfile.sv | 119 +++++++++++
 tb/tb_cp0_regfile.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 register file (SR, Cause, EPC, PrID) with interrupt/exception request
// Holds CP0 state beside the M stage and raises the same-cycle request for exception control.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_7701,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_din,
  input  logic [31:0]        pc_m,
  input  logic [4:0]         exc_code_m,
  input  logic [HWINT_W-1:0] hw_int,
  input  logic               exl_set,
  input  logic               exl_clr,
  input  logic               bd_set,
  input  logic               bd_clr,
  output logic               int_exc_req,
  output logic [31:0]        cp0_dout,
  output logic [31:0]        epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] im_q, im_d, ip_q;
  logic               ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        pc_m_minus4;
  logic               sr_we, epc_we, int_req, exc_req;
  logic [31:0]        sr_val, cause_val;

  assign sr_we       = cp0_we && (cp0_addr == ADDR_SR);
  assign epc_we      = cp0_we && (cp0_addr == ADDR_EPC);
  assign pc_m_minus4 = pc_m - 32'd4;

  assign int_req     = ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req     = ~exl_q & (exc_code_m != 5'd0);
  // Held low during reset so exception control never acts on half-reset state.
  assign int_exc_req = ~reset & (int_req | exc_req);

  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (sr_we) begin
      im_d  = cp0_din[10 +: HWINT_W];
      ie_d  = cp0_din[0];
      exl_d = cp0_din[1];
    end
    if (epc_we) begin
      epc_d = {cp0_din[31:2], 2'b00};
    end
    if (exl_clr) begin
      exl_d = 1'b0;
    end
    // Handler entry overrides mtc0 to EXL/EPC and any same-cycle eret.
    if (exl_set) begin
      exl_d      = 1'b1;
      bd_d       = bd_set;
      exc_code_d = int_req ? 5'd0 : exc_code_m;
      epc_d      = bd_set ? {pc_m_minus4[31:2], 2'b00} : {pc_m[31:2], 2'b00};
    end else if (bd_clr) begin
      bd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      ip_q       <= hw_int;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_val                  = 32'd0;
    sr_val[10 +: HWINT_W]   = im_q;
    sr_val[1]               = exl_q;
    sr_val[0]               = ie_q;
    cause_val               = 32'd0;
    cause_val[31]           = bd_q;
    cause_val[10 +: HWINT_W] = ip_q;
    cause_val[6:2]          = exc_code_q;
  end

  always_comb begin
    cp0_dout = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_dout = sr_val;
      ADDR_CAUSE: cp0_dout = cause_val;
      ADDR_EPC:   cp0_dout = epc_q;
      ADDR_PRID:  cp0_dout = PRID_VALUE;
      default:    cp0_dout = 32'd0;
    endcase
  end

  assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - self-checking bench for cp0_regfile against a word-level reference model
module tb_cp0_regfile;

  localparam logic [31:0] PRID    = 32'h0000_7701;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        reset;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic [31:0] pc_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        exl_set, exl_clr, bd_set, bd_clr;
  logic        int_exc_req;
  logic [31:0] cp0_dout;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk(clk), .reset(reset), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_din(cp0_din),
    .pc_m(pc_m), .exc_code_m(exc_code_m), .hw_int(hw_int), .exl_set(exl_set),
    .exl_clr(exl_clr), .bd_set(bd_set), .bd_clr(bd_clr), .int_exc_req(int_exc_req),
    .cp0_dout(cp0_dout), .epc_out(epc_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return !reset && (m_int() || (!m_sr[1] && exc_code_m != 5'd0));
  endfunction

  task automatic idle_inputs();
    cp0_we = 0; cp0_addr = 5'd0; cp0_din = 32'd0; pc_m = 32'd0; exc_code_m = 5'd0;
    hw_int = 6'd0; exl_set = 0; exl_clr = 0; bd_set = 0; bd_clr = 0;
  endtask

  // Called at a falling edge with inputs applied; checks, clocks once, advances the model.
  task automatic cycle();
    logic intr;
    #1;
    check_eq("req", {31'b0, int_exc_req}, {31'b0, m_req()});
    check_eq("dout", cp0_dout, m_read(cp0_addr));
    check_eq("epc_out", epc_out, m_epc);
    intr = m_int();
    @(posedge clk);
    if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_din & SR_MASK;
    if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_din & ~32'd3;
    if (exl_clr) m_sr[1] = 1'b0;
    m_cause[15:10] = hw_int;
    if (exl_set) begin
      m_sr[1]       = 1'b1;
      m_cause[31]   = bd_set;
      m_cause[6:2]  = intr ? 5'd0 : exc_code_m;
      m_epc         = (bd_set ? pc_m - 32'd4 : pc_m) & ~32'd3;
    end else if (bd_clr) begin
      m_cause[31] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    hw_int = 6'h3f; exc_code_m = 5'd9;
    #1 check_eq("rst_req", {31'b0, int_exc_req}, 32'd0);
    for (int a = 12; a <= 15; a++) begin
      cp0_addr = 5'(a);
      #1 check_eq("rst_dout", cp0_dout, (a == 15) ? PRID : 32'd0);
    end
    check_eq("rst_epc", epc_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle();

    // Interrupt entry
    cp0_we = 1; cp0_addr = 5'd12; cp0_din = 32'h0000_0401;
    cycle();
    cp0_we = 0; hw_int = 6'b000001;
    #1 check_eq("int_req", {31'b0, int_exc_req}, 32'd1);
    exl_set = 1; pc_m = 32'h0000_3010; bd_set = 0;
    cycle();
    exl_set = 0; cp0_addr = 5'd12;
    #1 check_eq("int_sr", cp0_dout, 32'h0000_0403);
    check_eq("int_blocked", {31'b0, int_exc_req}, 32'd0);
    cp0_addr = 5'd13;
    #1 check_eq("int_cause", cp0_dout, 32'h0000_0400);
    check_eq("int_epc", epc_out, 32'h0000_3010);
    cycle();

    // Exception in a delay slot with IE = 0
    hw_int = 0; exl_clr = 1;
    cycle();
    exl_clr = 0; cp0_we = 1; cp0_addr = 5'd12; cp0_din = 32'd0;
    cycle();
    cp0_we = 0; exc_code_m = 5'd12; pc_m = 32'h0000_3024; bd_set = 1;
    #1 check_eq("exc_req", {31'b0, int_exc_req}, 32'd1);
    exl_set = 1;
    cycle();
    exl_set = 0; bd_set = 0; exc_code_m = 0; cp0_addr = 5'd13;
    #1 check_eq("exc_epc", epc_out, 32'h0000_3020);
    check_eq("exc_cause", cp0_dout, 32'h8000_0030);

    // Nested requests blocked by EXL until eret
    cp0_we = 1; cp0_addr = 5'd12; cp0_din = 32'h0000_FC03;
    cycle();
    cp0_we = 0; hw_int = 6'h3f; exc_code_m = 5'd5;
    #1 check_eq("nest_req", {31'b0, int_exc_req}, 32'd0);
    cycle();
    cp0_addr = 5'd13;
    #1 check_eq("nest_cause", cp0_dout, 32'h8000_FC30);
    exc_code_m = 0; exl_clr = 1; bd_clr = 1;
    #1 check_eq("eret_req", {31'b0, int_exc_req}, 32'd0);
    cycle();
    exl_clr = 0; bd_clr = 0;
    #1 check_eq("post_eret_req", {31'b0, int_exc_req}, 32'd1);

    // Interrupt beats exception; exl_set beats mtc0 EPC
    exc_code_m = 5'd4; exl_set = 1; pc_m = 32'h0000_3000;
    cp0_we = 1; cp0_addr = 5'd14; cp0_din = 32'h0000_4000;
    cycle();
    cp0_we = 0; exl_set = 0; exc_code_m = 0; cp0_addr = 5'd13;
    #1 check_eq("prio_epc", epc_out, 32'h0000_3000);
    check_eq("prio_cause", cp0_dout, 32'h0000_FC00);
    hw_int = 0; exl_clr = 1;
    cycle();
    exl_clr = 0;

    // Register write masking and unmapped addresses
    cp0_we = 1; cp0_addr = 5'd14; cp0_din = 32'h0000_4003;
    cycle();
    cp0_we = 0;
    #1 check_eq("epc_align", epc_out, 32'h0000_4000);
    cp0_we = 1; cp0_addr = 5'd13; cp0_din = 32'hFFFF_FFFF;
    cycle();
    cp0_we = 1; cp0_addr = 5'd15; cp0_din = 32'd0;
    cycle();
    cp0_we = 0; cp0_addr = 5'd13;
    #1 check_eq("cause_ro", cp0_dout, 32'd0);
    cp0_addr = 5'd15;
    #1 check_eq("prid_ro", cp0_dout, PRID);
    cp0_addr = 5'd8;
    #1 check_eq("mfc0_8", cp0_dout, 32'd0);
    cycle();

    // Randomized traffic with a reset dropped in mid-run
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        exl_set = 1; pc_m = 32'h0000_5000; exc_code_m = 5'd3;
        cycle();
        do_reset();
      end
      cp0_we     = ($urandom_range(3) == 0);
      case ($urandom_range(4))
        0: cp0_addr = 5'd12;
        1: cp0_addr = 5'd13;
        2: cp0_addr = 5'd14;
        3: cp0_addr = 5'd15;
        default: cp0_addr = 5'($urandom);
      endcase
      cp0_din    = $urandom;
      pc_m       = $urandom;
      exc_code_m = ($urandom_range(2) == 0) ? 5'($urandom) : 5'd0;
      hw_int     = 6'($urandom);
      exl_set    = ($urandom_range(3) == 0);
      exl_clr    = ($urandom_range(4) == 0);
      bd_set     = 1'($urandom);
      bd_clr     = ($urandom_range(4) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
